// File: rtl/firebird7_in_gate1_tessent_tdr_w3.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_w3
//
// IJTAG test data register placed in front of the gate1 IJTAG data mux.
// The register has a shift stage (shreg) and an update stage. The update stage
// drives the mux select and its ijtag_data_in bus. The capture path loads a
// readback value, so the override can be observed through the scan path.
// A shift-length checker rejects any update whose preceding shift count is not
// exactly the register length L = WIDTH+1. A rejected update leaves the update
// stage untouched and sets a sticky length_error flag.
//
// Optional feature macro: FIREBIRD7_TDR_CAPTURE_EN
//   defined   : capture loads {ijtag_select, capture_data_in} (live mux view)
//   undefined : capture loads {ijtag_select, ijtag_data_out} (last written
//               value); capture_data_in is then unused.
//
// Ports
//   ijtag_tck        in   TDR clock, rising edge
//   ijtag_reset      in   asynchronous active-high reset
//   ijtag_sel        in   TDR selected; all controls are ignored when low
//   ijtag_ce         in   capture enable (highest priority)
//   ijtag_se         in   shift enable
//   ijtag_ue         in   update enable (lowest priority)
//   ijtag_si         in   scan in
//   ijtag_so         out  scan out = shreg[0]
//   capture_data_in  in   [WIDTH] observation of the mux data_out
//   ijtag_select     out  update-stage select bit, drives mux select
//   ijtag_data_out   out  [WIDTH] update-stage data, drives mux ijtag_data_in
//   length_error     out  sticky flag, set by a rejected update
// -----------------------------------------------------------------------------
module firebird7_in_gate1_tessent_tdr_w3 #(
  parameter int WIDTH = 3
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             length_error
);

  localparam int L     = WIDTH + 1;
  localparam int CNT_W = $clog2(L + 2);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(L);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(L + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_SHIFTING = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [L-1:0]     shreg_q, shreg_d;
  logic [L-1:0]     upd_q, upd_d;
  logic             err_q, err_d;

  // One action per edge: ce beats se beats ue, and nothing happens unless selected.
  logic do_cap, do_shift, do_upd, upd_ok;
  logic [WIDTH-1:0] cap_src;

  assign do_cap   = ijtag_sel & ijtag_ce;
  assign do_shift = ijtag_sel & ~ijtag_ce & ijtag_se;
  assign do_upd   = ijtag_sel & ~ijtag_ce & ~ijtag_se & ijtag_ue;

  // An update is only trusted after exactly L shifts following a capture.
  assign upd_ok = (state_q == ST_SHIFTING) && (cnt_q == CNT_LEN);

`ifdef FIREBIRD7_TDR_CAPTURE_EN
  assign cap_src = capture_data_in;
`else
  assign cap_src = upd_q[WIDTH-1:0];
  logic unused_capture_data;
  assign unused_capture_data = ^capture_data_in;
`endif

  // State register (also holds the shift and update stages)
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      upd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  // Next-state and shift counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (do_cap) begin
      state_d = ST_CAPTURED;
      cnt_d   = '0;
    end else if (do_shift) begin
      case (state_q)
        ST_CAPTURED: begin
          state_d = ST_SHIFTING;
          cnt_d   = CNT_ONE;
        end
        ST_SHIFTING: begin
          // Saturate one past L so an over-shift can never wrap back to L.
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end
        default: ;
      endcase
    end else if (do_upd) begin
      state_d = ST_IDLE;
    end
  end

  // Shift stage, update stage and error flag
  always_comb begin
    shreg_d = shreg_q;
    upd_d   = upd_q;
    err_d   = err_q;
    if (do_cap) begin
      shreg_d = {upd_q[WIDTH], cap_src};
    end else if (do_shift) begin
      shreg_d = {ijtag_si, shreg_q[L-1:1]};
    end else if (do_upd) begin
      if (upd_ok) begin
        upd_d = shreg_q;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign ijtag_so       = shreg_q[0];
  assign ijtag_select   = upd_q[WIDTH];
  assign ijtag_data_out = upd_q[WIDTH-1:0];
  assign length_error   = err_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3.sv
module tb_firebird7_in_gate1_tessent_tdr_w3;

  localparam int W = 3;
  localparam int L = W + 1;

  logic         tck = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
  logic [W-1:0] cap_in = '0;
  logic         so, select, lerr;
  logic [W-1:0] dout;

  int errors = 0;
  int checks = 0;

  // Reference model: whole register as a number, access phase as an integer.
  int        m_phase;   // 0 = idle, 1 = just captured, 2 = shifting
  int        m_shifts;  // shifts since capture, saturating at L+1
  bit [L-1:0] m_sh;
  bit [L-1:0] m_upd;
  bit         m_err;

  firebird7_in_gate1_tessent_tdr_w3 #(.WIDTH(W)) dut (
    .ijtag_tck       (tck),
    .ijtag_reset     (rst),
    .ijtag_sel       (sel),
    .ijtag_ce        (ce),
    .ijtag_se        (se),
    .ijtag_ue        (ue),
    .ijtag_si        (si),
    .ijtag_so        (so),
    .capture_data_in (cap_in),
    .ijtag_select    (select),
    .ijtag_data_out  (dout),
    .length_error    (lerr)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_shifts = 0; m_sh = '0; m_upd = '0; m_err = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit c, input bit sh, input bit u,
                            input bit i, input bit [W-1:0] cap);
    bit [W-1:0] src;
`ifdef FIREBIRD7_TDR_CAPTURE_EN
    src = cap;
`else
    src = m_upd[W-1:0];
`endif
    if (!s) return;
    if (c) begin
      m_sh = {m_upd[L-1], src};
      m_phase = 1;
      m_shifts = 0;
    end else if (sh) begin
      m_sh = (L'(i) << (L - 1)) | (m_sh >> 1);
      if (m_phase != 0) begin
        m_phase = 2;
        m_shifts = (m_shifts + 1 > L + 1) ? L + 1 : m_shifts + 1;
      end
    end else if (u) begin
      if (m_phase == 2 && m_shifts == L) begin
        m_upd = m_sh;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_phase = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".so"},     32'(so),     32'(m_sh[0]));
    chk({tag, ".select"}, 32'(select), 32'(m_upd[L-1]));
    chk({tag, ".data"},   32'(dout),   32'(m_upd[W-1:0]));
    chk({tag, ".lerr"},   32'(lerr),   32'(m_err));
  endtask

  // One clock cycle: drive after the falling edge, sample 1ns after the rising edge.
  task automatic step(input bit s, input bit c, input bit sh, input bit u, input bit i);
    @(negedge tck);
    sel = s; ce = c; se = sh; ue = u; si = i;
    @(posedge tck);
    model_edge(s, c, sh, u, i, cap_in);
    #1 compare_model("cyc");
  endtask

  task automatic async_reset_pulse();
    @(posedge tck);
    #3 rst = 1'b1;
    #1 model_reset();
    chk("rst.so", 32'(so), 0);
    chk("rst.select", 32'(select), 0);
    chk("rst.data", 32'(dout), 0);
    chk("rst.lerr", 32'(lerr), 0);
    @(negedge tck);
    #2 rst = 1'b0;
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0;
  endtask

  task automatic write_bits(input bit [L-1:0] v);
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < L; k++) step(1, 0, 1, 0, v[k]);
    step(1, 0, 0, 1, 0);
  endtask

  initial begin
    bit [L-1:0] exp_so;
    model_reset();
    #12 rst = 1'b0;

    // Reset state and release
    step(1, 0, 0, 0, 0);
    chk("release.select", 32'(select), 0);
    chk("release.data", 32'(dout), 0);
    async_reset_pulse();
    step(0, 0, 0, 0, 0);
    chk("release2.lerr", 32'(lerr), 0);

    // Nominal write, LSB first 1,0,1,1
    write_bits(4'b1101);
    chk("nominal.select", 32'(select), 1);
    chk("nominal.data", 32'(dout), 32'h5);
    chk("nominal.lerr", 32'(lerr), 0);

    // Short shift: rejected, then a correct access clears the flag
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < L - 1; k++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("short.data", 32'(dout), 32'h5);
    chk("short.lerr", 32'(lerr), 1);
    write_bits(4'b0010);
    chk("short_fix.select", 32'(select), 0);
    chk("short_fix.data", 32'(dout), 32'h2);
    chk("short_fix.lerr", 32'(lerr), 0);

    // Over-shift: counter saturates at L+1 and the update is rejected
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 1, 0, 1);
    chk("over.cnt", 32'(dut.cnt_q), 5);
    step(1, 0, 0, 1, 0);
    chk("over.lerr", 32'(lerr), 1);
    chk("over.data", 32'(dout), 32'h2);
    // Twelve shifts would land a wrapping 3-bit counter back on L
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("over12.lerr", 32'(lerr), 1);

    // Capture readback
    write_bits(4'b1101);
    cap_in = 3'b110;
`ifdef FIREBIRD7_TDR_CAPTURE_EN
    exp_so = 4'b1110;
`else
    exp_so = 4'b1101;
`endif
    step(1, 1, 0, 0, 0);
    chk("cap.so0", 32'(so), 32'(exp_so[0]));
    for (int k = 1; k < L; k++) begin
      step(1, 0, 1, 0, 0);
      chk($sformatf("cap.so%0d", k), 32'(so), 32'(exp_so[k]));
    end
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("cap.lerr", 32'(lerr), 0);

    // Deselect in the middle of a shift, then resume
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 0);
    chk("desel.cnt", 32'(dut.cnt_q), 2);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("desel.select", 32'(select), 0);
    chk("desel.data", 32'(dout), 32'h3);
    chk("desel.lerr", 32'(lerr), 0);

    // Reset during a shift discards the access; a bare update is then rejected
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    async_reset_pulse();
    chk("rstmid.data", 32'(dout), 0);
    step(1, 0, 0, 1, 0);
    chk("rstmid.lerr", 32'(lerr), 1);
    chk("rstmid.select", 32'(select), 0);

    // Randomized well-formed-ish accesses
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(L - 1, L + 1);
      cap_in = W'($urandom);
      step(1, 1, 0, 0, 0);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) step(0, $urandom % 2, 1, $urandom % 2, 0);
        step(1, 0, 1, 0, $urandom % 2);
      end
      step(1, 0, 0, 1, 0);
    end

    // Fully random control traffic (no shifting outside an access)
    for (int t = 0; t < 300; t++) begin
      bit s, c, sh, u;
      s  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 5) == 0);
      sh = ($urandom % 2) == 1;
      u  = ($urandom_range(0, 3) == 0);
      if (s && !c && sh && m_phase == 0) sh = 1'b0;
      cap_in = W'($urandom);
      step(s, c, sh, u, $urandom % 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
